// File: rtl/llr_pair_feeder.sv
// Single-frame LLR buffer feeding the stage-0 f/g node: saturates N raw channel LLRs
// on load, then streams the pairs (LLR[i], LLR[i+N/2]) one per handshake.
module llr_pair_feeder #(
  parameter int bitwidth = 7,
  parameter int in_width = 8,
  parameter int N        = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [in_width-1:0]       llr_i,
  input  logic                      llr_valid_i,
  output logic                      llr_ready_o,
  output logic [bitwidth-1:0]       r1_o,
  output logic [bitwidth-1:0]       r2_o,
  output logic                      pair_valid_o,
  input  logic                      pair_ready_i,
  output logic [$clog2(N/2)-1:0]    pair_idx_o,
  output logic                      last_o,
  output logic                      sat_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds data stable while valid=1 and ready=0.

  localparam int HALF = N / 2;
  localparam int IW   = $clog2(HALF);
  localparam int AW   = $clog2(N);
  localparam int MAXV = 2 ** (bitwidth - 1) - 1;

  localparam logic signed [in_width-1:0] P_IN_MAX  = in_width'(MAXV);
  localparam logic signed [in_width-1:0] P_IN_MIN  = in_width'(-MAXV);
  localparam logic [bitwidth-1:0]        P_OUT_MAX = bitwidth'(MAXV);
  localparam logic [bitwidth-1:0]        P_OUT_MIN = bitwidth'(-MAXV);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [AW-1:0]         r_wr_ptr;
  logic [IW-1:0]         r_rd_idx;
  logic                  r_sat;
  logic [bitwidth-1:0]   r_mem [N];

  logic signed [in_width-1:0] w_in;
  logic                  w_hi;
  logic                  w_lo;
  logic [bitwidth-1:0]   w_sat_llr;
  logic                  w_in_hs;
  logic                  w_pair_hs;
  logic                  w_wr_last;
  logic                  w_rd_last;
  logic                  w_emit;

  // The clamp is symmetric so the most-negative code never reaches the f/g stage,
  // where a negation of it would overflow.
  assign w_in      = llr_i;
  assign w_hi      = (w_in > P_IN_MAX);
  assign w_lo      = (w_in < P_IN_MIN);
  assign w_sat_llr = w_hi ? P_OUT_MAX : (w_lo ? P_OUT_MIN : w_in[bitwidth-1:0]);

  assign w_emit    = (r_state == S_EMIT);
  assign w_in_hs   = llr_valid_i && !w_emit;
  assign w_pair_hs = pair_ready_i && w_emit;
  assign w_wr_last = (r_wr_ptr == AW'(N - 1));
  assign w_rd_last = (r_rd_idx == IW'(HALF - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD: if (w_in_hs && w_wr_last) w_next_state = S_EMIT;
      S_EMIT: if (w_pair_hs && w_rd_last) w_next_state = S_LOAD;
      default: w_next_state = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_LOAD;
      r_wr_ptr <= '0;
      r_rd_idx <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_in_hs) begin
        r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
        if (w_hi || w_lo) r_sat <= 1'b1;
      end
      if (w_pair_hs) begin
        if (w_rd_last) begin
          r_rd_idx <= '0;
          r_sat    <= 1'b0;
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end
    end
  end

  // Frame storage carries no reset; it is always fully rewritten before EMIT.
  always_ff @(posedge clk_i) begin
    if (w_in_hs) r_mem[r_wr_ptr] <= w_sat_llr;
  end

  assign llr_ready_o  = !w_emit;
  assign pair_valid_o = w_emit;
  assign r1_o         = w_emit ? r_mem[{1'b0, r_rd_idx}] : '0;
  assign r2_o         = w_emit ? r_mem[{1'b1, r_rd_idx}] : '0;
  assign pair_idx_o   = w_emit ? r_rd_idx : '0;
  assign last_o       = w_emit && w_rd_last;
  assign sat_o        = r_sat;

endmodule

// File: tb/tb_llr_pair_feeder.sv
// Bench for llr_pair_feeder (N=8, bitwidth=7, in_width=8): loads frames, models the
// saturation and pairing independently and scoreboards every emitted pair.
module tb_llr_pair_feeder;

  localparam int BW   = 7;
  localparam int INW  = 8;
  localparam int NN   = 8;
  localparam int HALF = NN / 2;
  localparam int IW   = $clog2(HALF);
  localparam int W    = 2 * BW + IW + 1;

  logic            clk_i;
  logic            rst_ni;
  logic [INW-1:0]  llr_i;
  logic            llr_valid_i;
  logic            llr_ready_o;
  logic [BW-1:0]   r1_o;
  logic [BW-1:0]   r2_o;
  logic            pair_valid_o;
  logic            pair_ready_i;
  logic [IW-1:0]   pair_idx_o;
  logic            last_o;
  logic            sat_o;

  logic [W-1:0] exp_q[$];
  logic         exp_sat;
  int           checks;
  int           errors;

  llr_pair_feeder #(.bitwidth(BW), .in_width(INW), .N(NN)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .llr_i        (llr_i),
    .llr_valid_i  (llr_valid_i),
    .llr_ready_o  (llr_ready_o),
    .r1_o         (r1_o),
    .r2_o         (r2_o),
    .pair_valid_o (pair_valid_o),
    .pair_ready_i (pair_ready_i),
    .pair_idx_o   (pair_idx_o),
    .last_o       (last_o),
    .sat_o        (sat_o)
  );

  // Clock / watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors = errors + 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [BW-1:0] model_sat(input int v);
    if (v > 63) return 7'd63;
    if (v < -63) return 7'b1000001;
    return 7'(v);
  endfunction

  // Driver: all tasks start and end just after a falling edge.
  task automatic drive_frame(input int vals[NN], input bit gaps);
    exp_sat = 1'b0;
    for (int k = 0; k < NN; k++)
      if (vals[k] > 63 || vals[k] < -63) exp_sat = 1'b1;
    for (int k = 0; k < HALF; k++)
      exp_q.push_back({model_sat(vals[k]), model_sat(vals[k + HALF]), IW'(k), (k == HALF - 1)});
    for (int i = 0; i < NN; i++) begin
      llr_valid_i = 1'b1;
      llr_i       = INW'(vals[i]);
      @(negedge clk_i);
      if (gaps && i < NN - 1) begin
        llr_valid_i = 1'b0;
        llr_i       = INW'($urandom_range(0, 255));
        @(negedge clk_i);
      end
    end
    llr_valid_i = 1'b0;
  endtask

  // Scoreboard consumer: pops one expected pair per cycle the DUT presents one.
  task automatic collect_pairs(input int stall_idx, input int stall_cycles, input int abort_idx);
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    pair_ready_i = 1'b1;
    for (int k = 0; k < HALF; k++) begin
      checks = checks + 1;
      if (pair_valid_o !== 1'b1) begin
        errors = errors + 1;
        $display("FAIL pair_valid k=%0d: got %b expected 1", k, pair_valid_o);
      end
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL scoreboard_empty k=%0d: got empty queue expected entry", k);
        exp_v = '0;
      end else begin
        exp_v = exp_q.pop_front();
      end
      got_v = {r1_o, r2_o, pair_idx_o, last_o};
      checks = checks + 1;
      if (got_v !== exp_v) begin
        errors = errors + 1;
        $display("FAIL pair k=%0d: got r1=%h r2=%h idx=%0d last=%b expected r1=%h r2=%h idx=%0d last=%b",
                 k, r1_o, r2_o, pair_idx_o, last_o, exp_v[W-1 -: BW], exp_v[W-BW-1 -: BW],
                 exp_v[IW:1], exp_v[0]);
      end
      checks = checks + 1;
      if (sat_o !== exp_sat) begin
        errors = errors + 1;
        $display("FAIL sat_emit k=%0d: got %b expected %b", k, sat_o, exp_sat);
      end
      if (k == abort_idx) begin
        pair_ready_i = 1'b0;
        return;
      end
      if (k == stall_idx) begin
        pair_ready_i = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          llr_valid_i = ~llr_valid_i;
          llr_i       = 8'd99;
          @(negedge clk_i);
          got_v = {r1_o, r2_o, pair_idx_o, last_o};
          checks = checks + 1;
          if (got_v !== exp_v || pair_valid_o !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL stall_hold s=%0d: got %h valid=%b expected %h valid=1", s, got_v, pair_valid_o, exp_v);
          end
          checks = checks + 1;
          if (llr_ready_o !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL stall_llr_ready s=%0d: got %b expected 0", s, llr_ready_o);
          end
        end
        llr_valid_i  = 1'b0;
        pair_ready_i = 1'b1;
      end
      @(negedge clk_i);
    end
    checks = checks + 1;
    if ({llr_ready_o, pair_valid_o, sat_o, r1_o, r2_o, pair_idx_o, last_o} !== {1'b1, 1'b0, 1'b0, {(2*BW+IW+1){1'b0}}}) begin
      errors = errors + 1;
      $display("FAIL after_frame: got ready=%b valid=%b sat=%b r1=%h r2=%h idx=%0d last=%b expected ready=1 rest 0",
               llr_ready_o, pair_valid_o, sat_o, r1_o, r2_o, pair_idx_o, last_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; llr_valid_i = 1'b0; llr_i = '0; pair_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks = checks + 1;
    if ({llr_ready_o, pair_valid_o, r1_o, r2_o, pair_idx_o, last_o, sat_o} !== {1'b1, 1'b0, {(2*BW+IW+2){1'b0}}}) begin
      errors = errors + 1;
      $display("FAIL reset_state: got ready=%b valid=%b r1=%h r2=%h idx=%0d last=%b sat=%b expected ready=1 rest 0",
               llr_ready_o, pair_valid_o, r1_o, r2_o, pair_idx_o, last_o, sat_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_saturation();
    int vals[NN];
    vals = '{100, -128, -64, 63, -63, 5, -5, 0};
    drive_frame(vals, 1'b0);
    collect_pairs(-1, 0, -1);
    vals = '{63, -63, 0, 1, -1, 62, -62, 17};
    drive_frame(vals, 1'b0);
    collect_pairs(-1, 0, -1);
  endtask

  task automatic test_pairing();
    int vals[NN];
    vals = '{1, 2, 3, 4, -1, -2, -3, -4};
    drive_frame(vals, 1'b0);
    checks = checks + 1;
    if (pair_valid_o !== 1'b1 || pair_idx_o !== '0) begin
      errors = errors + 1;
      $display("FAIL first_pair_latency: got valid=%b idx=%0d expected valid=1 idx=0", pair_valid_o, pair_idx_o);
    end
    collect_pairs(-1, 0, -1);
  endtask

  task automatic test_backpressure();
    int vals[NN];
    vals = '{1, 2, 3, 4, -1, -2, -3, -4};
    drive_frame(vals, 1'b0);
    collect_pairs(1, 5, -1);
  endtask

  task automatic test_input_gaps();
    int vals[NN];
    for (int i = 0; i < NN; i++) vals[i] = int'($urandom_range(0, 255)) - 128;
    drive_frame(vals, 1'b1);
    collect_pairs(-1, 0, -1);
  endtask

  task automatic test_back_to_back();
    int vals[NN];
    for (int i = 0; i < NN; i++) vals[i] = int'($urandom_range(0, 255)) - 128;
    vals[0] = 120;
    drive_frame(vals, 1'b0);
    collect_pairs(-1, 0, -1);
    vals = '{7, 7, 7, 7, 7, 7, 7, 7};
    drive_frame(vals, 1'b0);
    collect_pairs(-1, 0, -1);
  endtask

  task automatic test_reset_mid();
    int vals[NN];
    for (int i = 0; i < 3; i++) begin
      llr_valid_i = 1'b1;
      llr_i       = INW'(i + 40);
      @(negedge clk_i);
    end
    llr_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks = checks + 1;
    if (pair_valid_o !== 1'b0 || llr_ready_o !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reset_mid_load: got valid=%b ready=%b expected valid=0 ready=1", pair_valid_o, llr_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    vals = '{9, 10, 11, 12, -9, -10, -11, -12};
    drive_frame(vals, 1'b0);
    collect_pairs(-1, 0, -1);
    vals = '{90, 20, 30, 40, -20, -30, -40, -50};
    drive_frame(vals, 1'b0);
    collect_pairs(-1, 0, 2);
    rst_ni = 1'b0;
    #1;
    checks = checks + 1;
    if ({pair_valid_o, llr_ready_o, sat_o, r1_o, pair_idx_o} !== {1'b0, 1'b1, 1'b0, {(BW+IW){1'b0}}}) begin
      errors = errors + 1;
      $display("FAIL reset_mid_emit: got valid=%b ready=%b sat=%b r1=%h idx=%0d expected valid=0 ready=1 sat=0 r1=0 idx=0",
               pair_valid_o, llr_ready_o, sat_o, r1_o, pair_idx_o);
    end
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    vals = '{-5, 6, -7, 8, 15, -16, 17, -18};
    drive_frame(vals, 1'b0);
    collect_pairs(-1, 0, -1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_sat = 1'b0;
    test_reset();
    test_saturation();
    test_pairing();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_reset_mid();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/llr_pair_feeder.md
Name: llr_pair_feeder

Overview:
Upstream stage of the f/g node processor in the SC polar decoder. Accepts one frame of N raw channel LLRs serially over a valid/ready handshake and saturates each to the decoder's (5,1)+sign format. It then streams the N/2 stage-0 operand pairs (LLR[i], LLR[i+N/2]) to the f-function and g-function inputs over a second valid/ready handshake. Single-frame buffer: load and emit phases do not overlap.

Parameters:
bitwidth, 7, width of the output LLRs: two's complement, (5,1) quantization plus sign
in_width, 8, width of the raw input LLRs: two's complement, same LSB weight as the output; must be >= bitwidth
N, 32, code length: power of 2, >= 4

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
llr_i  input  in_width  raw channel LLR
llr_valid_i  input  1  llr_i is valid
llr_ready_o  output  1  block accepts llr_i
r1_o  output  bitwidth  LLR[pair_idx_o], to r1 of the f/g stage
r2_o  output  bitwidth  LLR[pair_idx_o+N/2], to r2 of the f/g stage
pair_valid_o  output  1  r1_o, r2_o and pair_idx_o are valid
pair_ready_i  input  1  the downstream stage consumes the pair
pair_idx_o  output  $clog2(N/2)  index i of the current pair
last_o  output  1  the current pair is pair N/2-1
sat_o  output  1  at least one LLR was saturated in the current frame

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state = LOAD; wr_ptr = 0; rd_idx = 0; sat flag = 0.
  - Outputs: llr_ready_o = 1, pair_valid_o = 0, r1_o = r2_o = 0, pair_idx_o = 0, last_o = 0, sat_o = 0.
  - LLR storage (N x bitwidth registers) is not reset.
- Saturation:
  - Clamp a signed in_width value to [-(2^(bitwidth-1)-1), +(2^(bitwidth-1)-1)]. For bitwidth=7 the range is [-63, +63].
  - The most-negative code (-64) is never produced, so the downstream two's-complement negation cannot overflow.
  - Values inside the range pass through unchanged (sign-truncate to bitwidth).
  - Any clamp sets the sat flag.
- State LOAD:
  - llr_ready_o = 1, pair_valid_o = 0.
  - On llr_valid_i and llr_ready_o: mem[wr_ptr] <= sat(llr_i); wr_ptr++.
  - Handshake with wr_ptr = N-1: go to EMIT next cycle, rd_idx = 0, wr_ptr = 0.
  - No handshake: no change. Gaps in llr_valid_i are allowed.
- State EMIT:
  - llr_ready_o = 0; llr_i and llr_valid_i are ignored.
  - pair_valid_o = 1; r1_o = mem[rd_idx]; r2_o = mem[rd_idx+N/2]; pair_idx_o = rd_idx; last_o = (rd_idx == N/2-1).
  - These outputs are driven from registers and stay stable while pair_valid_o=1 and pair_ready_i=0.
  - On pair handshake: rd_idx++.
  - Handshake with last_o = 1: go to LOAD next cycle; rd_idx = 0; sat flag cleared.
- sat_o: equals the sat flag. It is valid throughout EMIT and holds the final frame value until the last pair handshake.
- Latency:
  - First pair is valid on the cycle after the N-th LLR handshake.
  - Back-to-back: one pair per cycle when pair_ready_i is held at 1. A full frame takes N + N/2 cycles minimum.
- Outside EMIT: r1_o, r2_o, pair_idx_o and last_o are 0.
- pair_ready_i while pair_valid_o=0: ignored.
- Reset asserted mid-LOAD or mid-EMIT: the partial frame is discarded and the block returns to the reset state immediately.

Test Plan:
- Saturation (bitwidth=7, in_width=8): inputs +100, -128, -64, +63, -63, 5, -5 -> stored 63, -63, -63, 63, -63, 5, -5; sat_o=1 in EMIT. A frame with all |llr|<=63 -> sat_o=0.
- Pairing (N=8): inputs 1,2,3,4,-1,-2,-3,-4, pair_ready_i=1 -> pairs (1,-1),(2,-2),(3,-3),(4,-4) on consecutive cycles. pair_idx_o = 0..3; last_o=1 only with idx 3. First pair one cycle after the 8th input.
- Backpressure (N=8): pair_ready_i=0 for 5 cycles at idx 1 -> r1_o/r2_o/pair_idx_o stay (2,-2,1). llr_ready_o stays 0; llr_valid_i pulses during EMIT are not accepted.
- Input gaps: llr_valid_i toggled 1,0,1,0,... -> frame still completes after exactly N accepted handshakes with correct contents.
- Back-to-back frames: frame A then frame B (all +7) -> llr_ready_o=1 on the cycle after A's last pair; B's pairs are all (7,7); sat_o cleared between frames.
- Reset mid-operation: rst_ni=0 after 3 loads, or during EMIT at idx 2 -> pair_valid_o=0 and llr_ready_o=1 immediately. The next full frame is emitted correctly from idx 0.
